// File: rtl/matmul_axil_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : matmul_axil_engine_if
// Description : AXI4-Lite bundle between the matrix multiplier S00_AXI master
//               port and the matmul_axil_engine register/compute slave.
// Revision    : 1.0  initial release
// ============================================================================
interface matmul_axil_engine_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);

  // write address channel
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;

  // write data channel
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;

  // write response channel
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  // read address channel
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;

  // read data channel
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid,
    output wdata, wstrb, wvalid,
    output bready,
    output araddr, arprot, arvalid,
    output rready,
    input  awready, wready,
    input  bresp, bvalid,
    input  arready,
    input  rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid,
    input  wdata, wstrb, wvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    input  rready,
    output awready, wready,
    output bresp, bvalid,
    output arready,
    output rdata, rresp, rvalid
  );

endinterface
`default_nettype wire

// File: rtl/matmul_axil_engine.sv
`default_nettype none
// ============================================================================
// Module      : matmul_axil_engine
// Description : AXI4-Lite slave holding N x N signed operand matrices A and B,
//               a control/status block and result matrix C = A x B. The
//               product is built with one multiply-accumulate per clock.
// Revision    : 1.0  initial release
// ============================================================================
module matmul_axil_engine #(
  parameter int N                  = 4,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 10
) (
  input  logic                 s00_axi_aclk,
  input  logic                 s00_axi_aresetn,
  matmul_axil_engine_if.slave  s00_axi,
  output logic                 irq_done
);

  localparam int c_NN = N * N;
  localparam int c_IW = $clog2(c_NN);
  localparam int c_CW = $clog2(N);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(N - 1);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_MAC  = 2'd1;
  localparam logic [1:0] c_ST_WB   = 2'd2;
  localparam logic [1:0] c_ST_FIN  = 2'd3;

  // addr[9:8] selects the register region, addr[7:2] the word inside it
  localparam logic [1:0] c_RG_CSR = 2'd0;
  localparam logic [1:0] c_RG_A   = 2'd1;
  localparam logic [1:0] c_RG_B   = 2'd2;
  localparam logic [1:0] c_RG_C   = 2'd3;

  // ---------------------------------------------------------------- storage
  logic [31:0]     r_mat_a [c_NN];
  logic [31:0]     r_mat_b [c_NN];
  logic [31:0]     r_mat_c [c_NN];

  logic            r_aw_accept;
  logic            r_bvalid;
  logic [1:0]      r_bresp;
  logic            r_ar_accept;
  logic            r_rvalid;
  logic [31:0]     r_rdata;

  logic            r_ie;
  logic            r_busy;
  logic            r_done;

  logic [1:0]      r_state;
  logic [1:0]      w_state_next;
  logic [c_CW-1:0] r_i;
  logic [c_CW-1:0] r_j;
  logic [c_CW-1:0] r_k;
  logic [31:0]     r_acc;

  // ---------------------------------------------------------- write decode
  logic [1:0]      w_wr_region;
  logic [5:0]      w_wr_off;
  logic            w_wr_in_mat;
  logic [c_IW-1:0] w_wr_idx;
  logic            w_wr_en;
  logic            w_wr_ctrl;
  logic            w_wr_mat;
  logic            w_wr_err;
  logic            w_wr_a;
  logic            w_wr_b;
  logic            w_start_req;

  assign w_wr_region = s00_axi.awaddr[9:8];
  assign w_wr_off    = s00_axi.awaddr[7:2];
  assign w_wr_in_mat = ({1'b0, w_wr_off} < 7'(c_NN));
  assign w_wr_idx    = w_wr_off[c_IW-1:0];

  // awready and wready share one pulse, so the handshake is their overlap
  assign w_wr_en     = r_aw_accept & s00_axi.awvalid & s00_axi.wvalid;
  assign w_wr_ctrl   = w_wr_en & (w_wr_region == c_RG_CSR) & (w_wr_off == 6'd0);
  assign w_wr_mat    = w_wr_en & (w_wr_region != c_RG_CSR) & w_wr_in_mat;
  assign w_wr_err    = w_wr_mat & r_busy;
  assign w_wr_a      = w_wr_mat & ~r_busy & (w_wr_region == c_RG_A);
  assign w_wr_b      = w_wr_mat & ~r_busy & (w_wr_region == c_RG_B);
  assign w_start_req = w_wr_ctrl & s00_axi.wstrb[0] & s00_axi.wdata[0];

  // ----------------------------------------------------------- read decode
  logic [1:0]      w_rd_region;
  logic [5:0]      w_rd_off;
  logic            w_rd_in_mat;
  logic [c_IW-1:0] w_rd_idx;
  logic            w_rd_en;
  logic [31:0]     w_rd_data;

  assign w_rd_region = s00_axi.araddr[9:8];
  assign w_rd_off    = s00_axi.araddr[7:2];
  assign w_rd_in_mat = ({1'b0, w_rd_off} < 7'(c_NN));
  assign w_rd_idx    = w_rd_off[c_IW-1:0];
  assign w_rd_en     = r_ar_accept & s00_axi.arvalid;

  // byte-lane merge of a write into an existing word
  function automatic logic [31:0] f_merge(input logic [31:0] old_word,
                                          input logic [31:0] new_word,
                                          input logic [3:0]  strb);
    f_merge = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) f_merge[8*b +: 8] = new_word[8*b +: 8];
    end
  endfunction

  // ------------------------------------------------------------- datapath
  logic [c_IW-1:0] w_a_idx;
  logic [c_IW-1:0] w_b_idx;
  logic [c_IW-1:0] w_c_idx;
  logic [31:0]     w_prod;
  logic            w_row_end;
  logic            w_last_elem;

  assign w_a_idx     = c_IW'(int'(r_i) * N + int'(r_k));
  assign w_b_idx     = c_IW'(int'(r_k) * N + int'(r_j));
  assign w_c_idx     = c_IW'(int'(r_i) * N + int'(r_j));
  // the low 32 bits of a signed 64-bit product equal those of the unsigned
  // 32x32 product, and the accumulator keeps only those 32 bits anyway
  assign w_prod      = r_mat_a[w_a_idx] * r_mat_b[w_b_idx];
  assign w_row_end   = (r_j == c_LAST);
  assign w_last_elem = w_row_end & (r_i == c_LAST);

  // FSM control strobes
  logic w_begin;
  logic w_mac;
  logic w_wb;
  logic w_fin;

  // state register
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) r_state <= c_ST_IDLE;
    else                  r_state <= w_state_next;
  end

  // next-state: one MAC pass of N cycles per element, then a writeback
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_ST_IDLE: if (w_start_req)       w_state_next = c_ST_MAC;
      c_ST_MAC:  if (r_k == c_LAST)     w_state_next = c_ST_WB;
      c_ST_WB:   w_state_next = w_last_elem ? c_ST_FIN : c_ST_MAC;
      c_ST_FIN:  w_state_next = c_ST_IDLE;
      default:   w_state_next = c_ST_IDLE;
    endcase
  end

  // state decode into datapath strobes; start is honoured only when idle
  always_comb begin
    w_begin = 1'b0;
    w_mac   = 1'b0;
    w_wb    = 1'b0;
    w_fin   = 1'b0;
    case (r_state)
      c_ST_IDLE: w_begin = w_start_req;
      c_ST_MAC:  w_mac   = 1'b1;
      c_ST_WB:   w_wb    = 1'b1;
      c_ST_FIN:  w_fin   = 1'b1;
      default:   ;
    endcase
  end

  // indices, accumulator and busy/done flags
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_i    <= '0;
      r_j    <= '0;
      r_k    <= '0;
      r_acc  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      if (w_begin) begin
        r_i    <= '0;
        r_j    <= '0;
        r_k    <= '0;
        r_acc  <= '0;
        r_busy <= 1'b1;
        r_done <= 1'b0;
      end
      if (w_mac) begin
        r_acc <= r_acc + w_prod;
        r_k   <= (r_k == c_LAST) ? '0 : r_k + 1'b1;
      end
      if (w_wb) begin
        r_acc <= '0;
        if (w_last_elem) begin
          r_i <= '0;
          r_j <= '0;
        end else if (w_row_end) begin
          r_i <= r_i + 1'b1;
          r_j <= '0;
        end else begin
          r_j <= r_j + 1'b1;
        end
      end
      if (w_fin) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end
  end

  // operand writes from the bus and result writeback; contents need no reset
  always_ff @(posedge s00_axi_aclk) begin
    if (w_wr_a) r_mat_a[w_wr_idx] <= f_merge(r_mat_a[w_wr_idx], s00_axi.wdata, s00_axi.wstrb);
    if (w_wr_b) r_mat_b[w_wr_idx] <= f_merge(r_mat_b[w_wr_idx], s00_axi.wdata, s00_axi.wstrb);
    if (w_wb)   r_mat_c[w_c_idx]  <= r_acc;
  end

  // interrupt enable stays writable even while a product is running
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn)                  r_ie <= 1'b0;
    else if (w_wr_ctrl & s00_axi.wstrb[0]) r_ie <= s00_axi.wdata[1];
  end

  // write channel: one-cycle accept pulse, response held until bready
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_aw_accept <= 1'b0;
      r_bvalid    <= 1'b0;
      r_bresp     <= 2'b00;
    end else begin
      r_aw_accept <= ~r_aw_accept & s00_axi.awvalid & s00_axi.wvalid & ~r_bvalid;
      if (w_wr_en) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_wr_err ? 2'b10 : 2'b00;
      end else if (r_bvalid & s00_axi.bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // read data mux; unmapped words read as zero
  always_comb begin
    w_rd_data = '0;
    case (w_rd_region)
      c_RG_CSR: begin
        case (w_rd_off)
          6'd0:    w_rd_data = {30'd0, r_ie, 1'b0};
          6'd1:    w_rd_data = {30'd0, r_done, r_busy};
          6'd2:    w_rd_data = 32'(N);
          default: ;
        endcase
      end
      c_RG_A:  if (w_rd_in_mat) w_rd_data = r_mat_a[w_rd_idx];
      c_RG_B:  if (w_rd_in_mat) w_rd_data = r_mat_b[w_rd_idx];
      c_RG_C:  if (w_rd_in_mat) w_rd_data = r_mat_c[w_rd_idx];
      default: ;
    endcase
  end

  // read channel: registered data held stable until rready
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_ar_accept <= 1'b0;
      r_rvalid    <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_ar_accept <= ~r_ar_accept & s00_axi.arvalid & ~r_rvalid;
      if (w_rd_en) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_data;
      end else if (r_rvalid & s00_axi.rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign s00_axi.awready = r_aw_accept;
  assign s00_axi.wready  = r_aw_accept;
  assign s00_axi.bvalid  = r_bvalid;
  assign s00_axi.bresp   = r_bresp;
  assign s00_axi.arready = r_ar_accept;
  assign s00_axi.rvalid  = r_rvalid;
  assign s00_axi.rdata   = r_rdata;
  assign s00_axi.rresp   = 2'b00;
  assign irq_done        = r_done & r_ie;

  // protection bits and sub-word address bits carry no meaning here
  logic w_unused;
  assign w_unused = ^{s00_axi.awprot, s00_axi.arprot, s00_axi.awaddr[1:0], s00_axi.araddr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_matmul_axil_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_matmul_axil_engine
// Description : Directed self-checking bench for matmul_axil_engine (N = 4).
// Revision    : 1.0  initial release
// ============================================================================
module tb_matmul_axil_engine;

  logic clk = 1'b0;
  logic aresetn = 1'b1;
  logic irq_done;

  matmul_axil_engine_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) s00_axi ();

  matmul_axil_engine #(.N(4), .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(10)) dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (aresetn),
    .s00_axi         (s00_axi),
    .irq_done        (irq_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // edge counter used to time start-to-done latency
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  function automatic logic [9:0] a_addr(input int i, input int j);
    return 10'h100 + 10'(4 * (i * 4 + j));
  endfunction
  function automatic logic [9:0] b_addr(input int i, input int j);
    return 10'h200 + 10'(4 * (i * 4 + j));
  endfunction
  function automatic logic [9:0] c_addr(input int i, input int j);
    return 10'h300 + 10'(4 * (i * 4 + j));
  endfunction

  function automatic logic [31:0] outs_now();
    return {22'd0, s00_axi.awready, s00_axi.wready, s00_axi.bvalid, s00_axi.bresp,
            s00_axi.arready, s00_axi.rvalid, s00_axi.rresp, irq_done};
  endfunction

  // full write transaction; hs returns the edge count of the handshake edge
  task automatic axi_write(input logic [9:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output int hs);
    int t = 0;
    s00_axi.awaddr = addr; s00_axi.wdata = data; s00_axi.wstrb = strb;
    s00_axi.awvalid = 1'b1; s00_axi.wvalid = 1'b1; s00_axi.bready = 1'b1;
    do begin @(posedge clk); #1; t++; end while (!s00_axi.bvalid && t < 20);
    hs = cyc;
    s00_axi.awvalid = 1'b0; s00_axi.wvalid = 1'b0;
    if (!s00_axi.bvalid) chk("wr_timeout", {31'd0, s00_axi.bvalid}, 32'd1);
    resp = s00_axi.bresp;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [9:0] addr, input logic [31:0] data);
    logic [1:0] r; int h;
    axi_write(addr, data, 4'hF, r, h);
  endtask

  task automatic axi_read(input logic [9:0] addr, output logic [31:0] data);
    int t = 0;
    s00_axi.araddr = addr; s00_axi.arvalid = 1'b1; s00_axi.rready = 1'b1;
    do begin @(posedge clk); #1; t++; end while (!s00_axi.rvalid && t < 20);
    s00_axi.arvalid = 1'b0;
    if (!s00_axi.rvalid) chk("rd_timeout", {31'd0, s00_axi.rvalid}, 32'd1);
    data = s00_axi.rdata;
    @(posedge clk); #1;
  endtask

  task automatic rd_chk(input string tag, input logic [9:0] addr, input logic [31:0] want);
    logic [31:0] d;
    axi_read(addr, d);
    chk(tag, d, want);
  endtask

  // poll STATUS until done, bounded
  task automatic wait_done(input string tag);
    logic [31:0] st; int t = 0;
    do begin axi_read(10'h004, st); t++; end while (st[1] !== 1'b1 && t < 60);
    chk(tag, st, 32'h2);
  endtask

  // wait for irq_done and check it lands exactly 81 edges after the start handshake
  task automatic wait_irq(input string tag, input int hs);
    int t = 0;
    while (!irq_done && t < 200) begin @(posedge clk); #1; t++; end
    chk(tag, 32'(cyc - hs), 32'd81);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] held;
    logic        bad;
    int          hs, hs0, t;

    s00_axi.awaddr = '0; s00_axi.awprot = '0; s00_axi.awvalid = 1'b0;
    s00_axi.wdata = '0; s00_axi.wstrb = '0; s00_axi.wvalid = 1'b0; s00_axi.bready = 1'b0;
    s00_axi.araddr = '0; s00_axi.arprot = '0; s00_axi.arvalid = 1'b0; s00_axi.rready = 1'b0;

    // reset
    #1 aresetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", outs_now(), 32'd0);
    chk("rst_rdata", s00_axi.rdata, 32'd0);
    #1 aresetn = 1'b1;
    @(posedge clk); #1;
    rd_chk("rst_status", 10'h004, 32'd0);
    rd_chk("rst_ctrl", 10'h000, 32'd0);
    rd_chk("dim", 10'h008, 32'd4);
    rd_chk("unmapped_rd", 10'h00C, 32'd0);
    axi_write(10'h0FC, 32'hDEADBEEF, 4'hF, resp, hs);
    chk("unmapped_wr_resp", {30'd0, resp}, 32'd0);

    // 1: identity x B
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        wr(a_addr(i, j), (i == j) ? 32'd1 : 32'd0);
        wr(b_addr(i, j), 32'(i * 4 + j + 1));
      end
    wr(10'h000, 32'h1);
    wait_done("t1_done");
    chk("t1_irq", {31'd0, irq_done}, 32'd0);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        rd_chk($sformatf("t1_c%0d%0d", i, j), c_addr(i, j), 32'(i * 4 + j + 1));

    // 2: all-2 x all-3 with interrupt enabled
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        wr(a_addr(i, j), 32'd2);
        wr(b_addr(i, j), 32'd3);
      end
    axi_write(10'h000, 32'h3, 4'hF, resp, hs);
    wait_irq("t2_latency", hs);
    rd_chk("t2_status", 10'h004, 32'h2);
    rd_chk("t2_ctrl", 10'h000, 32'h2);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        rd_chk($sformatf("t2_c%0d%0d", i, j), c_addr(i, j), 32'd24);
    axi_write(10'h000, 32'h3, 4'hF, resp, hs);
    chk("t2_irq_clear", {31'd0, irq_done}, 32'd0);
    wait_irq("t2_latency2", hs);

    // 3: signed wrap, -1 * 0x7FFFFFFF; also a byte-masked write
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        wr(a_addr(i, j), (i == 0 && j == 0) ? 32'hFFFF_FFFF : 32'd0);
        wr(b_addr(i, j), (i == 0 && j == 0) ? 32'h7FFF_FFFF : 32'd0);
      end
    axi_write(a_addr(3, 3), 32'h1234_5678, 4'b0101, resp, hs);
    rd_chk("t3_wstrb", a_addr(3, 3), 32'h0034_0078);
    axi_write(10'h000, 32'h3, 4'hF, resp, hs);
    wait_irq("t3_latency", hs);
    rd_chk("t3_c00", c_addr(0, 0), 32'h8000_0001);
    rd_chk("t3_c01", c_addr(0, 1), 32'd0);

    // 4: writes while busy
    axi_write(10'h000, 32'h3, 4'hF, resp, hs0);
    axi_write(a_addr(0, 0), 32'd5, 4'hF, resp, hs);
    chk("t4_busy_bresp", {30'd0, resp}, 32'd2);
    axi_write(10'h000, 32'h3, 4'hF, resp, hs);
    chk("t4_restart_bresp", {30'd0, resp}, 32'd0);
    rd_chk("t4_status_busy", 10'h004, 32'h1);
    rd_chk("t4_a00_kept", a_addr(0, 0), 32'hFFFF_FFFF);
    wait_irq("t4_latency", hs0);
    rd_chk("t4_c00", c_addr(0, 0), 32'h8000_0001);

    // 5: asynchronous reset in the middle of MAC
    wr(10'h000, 32'h3);
    repeat (20) @(posedge clk);
    #3 aresetn = 1'b0;
    #1;
    chk("t5_rst_outs", outs_now(), 32'd0);
    chk("t5_rst_rdata", s00_axi.rdata, 32'd0);
    @(posedge clk);
    #2 aresetn = 1'b1;
    @(posedge clk); #1;
    rd_chk("t5_status", 10'h004, 32'd0);
    rd_chk("t5_ctrl", 10'h000, 32'd0);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        wr(a_addr(i, j), (i == 0 && j == 0) ? 32'd3 : 32'd0);
        wr(b_addr(i, j), (i == 0 && j == 0) ? 32'd7 : 32'd0);
      end
    wr(10'h000, 32'h1);
    wait_done("t5_done");
    rd_chk("t5_c00", c_addr(0, 0), 32'd21);
    rd_chk("t5_c11", c_addr(1, 1), 32'd0);

    // 6a: bready held low for 10 cycles with a second write pending
    s00_axi.awaddr = a_addr(1, 1); s00_axi.wdata = 32'h55; s00_axi.wstrb = 4'hF;
    s00_axi.awvalid = 1'b1; s00_axi.wvalid = 1'b1; s00_axi.bready = 1'b0;
    t = 0;
    do begin @(posedge clk); #1; t++; end while (!s00_axi.bvalid && t < 20);
    chk("t6_bvalid", {31'd0, s00_axi.bvalid}, 32'd1);
    s00_axi.awaddr = a_addr(1, 2); s00_axi.wdata = 32'h66;
    bad = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      bad |= s00_axi.awready | s00_axi.wready | !s00_axi.bvalid | (s00_axi.bresp != 2'b00);
    end
    chk("t6_bhold", {31'd0, bad}, 32'd0);
    s00_axi.awvalid = 1'b0; s00_axi.wvalid = 1'b0; s00_axi.bready = 1'b1;
    @(posedge clk); #1;
    chk("t6_bclear", {31'd0, s00_axi.bvalid}, 32'd0);
    rd_chk("t6_a11", a_addr(1, 1), 32'h55);
    rd_chk("t6_a12", a_addr(1, 2), 32'd0);

    // 6b: rready held low for 10 cycles with a second read pending
    s00_axi.araddr = a_addr(1, 1); s00_axi.arvalid = 1'b1; s00_axi.rready = 1'b0;
    t = 0;
    do begin @(posedge clk); #1; t++; end while (!s00_axi.rvalid && t < 20);
    held = s00_axi.rdata;
    chk("t6_rdata", held, 32'h55);
    s00_axi.araddr = 10'h008;
    bad = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      bad |= s00_axi.arready | !s00_axi.rvalid | (s00_axi.rdata !== held);
    end
    chk("t6_rhold", {31'd0, bad}, 32'd0);
    s00_axi.arvalid = 1'b0; s00_axi.rready = 1'b1;
    @(posedge clk); #1;
    chk("t6_rclear", {31'd0, s00_axi.rvalid}, 32'd0);

    // simultaneous read and write of one word: read sees the old value
    s00_axi.awaddr = a_addr(2, 2); s00_axi.wdata = 32'h99; s00_axi.wstrb = 4'hF;
    s00_axi.awvalid = 1'b1; s00_axi.wvalid = 1'b1; s00_axi.bready = 1'b1;
    s00_axi.araddr = a_addr(2, 2); s00_axi.arvalid = 1'b1; s00_axi.rready = 1'b1;
    t = 0;
    do begin @(posedge clk); #1; t++; end while (!(s00_axi.bvalid && s00_axi.rvalid) && t < 20);
    s00_axi.awvalid = 1'b0; s00_axi.wvalid = 1'b0; s00_axi.arvalid = 1'b0;
    chk("rw_same_old", s00_axi.rdata, 32'd0);
    @(posedge clk); #1;
    rd_chk("rw_same_new", a_addr(2, 2), 32'h99);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
